// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier with a start/done handshake.
// Fixed latency: MUL, NORM and ROUND take one cycle each, and the result is registered out of DONE.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int ROUND = 1,
  localparam int BIAS = (1 << (EXP_W - 1)) - 1,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         zero
);

  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic signed [XW-1:0] EMAX_X = XW'(EMAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]              state;
  logic                    sign_r;
  logic                    spec_zero;
  logic                    spec_inf;
  logic [EXP_W-1:0]        exp_a;
  logic [EXP_W-1:0]        exp_b;
  logic [MAN_W-1:0]        man_a;
  logic [MAN_W-1:0]        man_b;
  logic [PW-1:0]           prod;
  logic signed [XW-1:0]    exp_r;
  logic [MAN_W-1:0]        man_r;
  logic                    guard_r;
  logic                    sticky_r;

  logic                    a_exp_zero;
  logic                    b_exp_zero;
  logic                    a_exp_ones;
  logic                    b_exp_ones;
  logic [PW-1:0]           mul_a;
  logic [PW-1:0]           mul_b;
  logic signed [XW-1:0]    exp_sum;
  logic [MAN_W-1:0]        norm_man;
  logic                    norm_guard;
  logic                    norm_sticky;
  logic signed [XW-1:0]    norm_exp;
  logic                    round_inc;
  logic                    round_carry;
  logic [MAN_W-1:0]        rnd_man;
  logic signed [XW-1:0]    rnd_exp;
  logic                    range_ovf;
  logic                    range_ufl;

  assign busy = (state == S_MUL) || (state == S_NORM) || (state == S_ROUND);

  // Zero/denormal and infinity detection on the raw inputs, latched when a start is accepted.
  assign a_exp_zero = (a[W-2:MAN_W] == '0);
  assign b_exp_zero = (b[W-2:MAN_W] == '0);
  assign a_exp_ones = (a[W-2:MAN_W] == '1);
  assign b_exp_ones = (b[W-2:MAN_W] == '1);

  assign mul_a   = {{(MAN_W + 1){1'b0}}, 1'b1, man_a};
  assign mul_b   = {{(MAN_W + 1){1'b0}}, 1'b1, man_b};
  assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_X;

  // A product of two [1,2) significands lies in [1,4), so a single right shift always normalises it.
  always_comb begin
    norm_man    = prod[2*MAN_W-1:MAN_W];
    norm_guard  = prod[MAN_W-1];
    norm_sticky = |prod[MAN_W-2:0];
    norm_exp    = exp_r;
    if (prod[PW-1]) begin
      norm_man    = prod[2*MAN_W:MAN_W+1];
      norm_guard  = prod[MAN_W];
      norm_sticky = |prod[MAN_W-1:0];
      norm_exp    = exp_r + XW'(1);
    end
  end

  assign round_inc              = (ROUND != 0) && guard_r && (sticky_r || man_r[0]);
  assign {round_carry, rnd_man} = {1'b0, man_r} + (MAN_W + 1)'(round_inc);
  assign rnd_exp                = exp_r + XW'(round_carry);

  assign range_ovf = (exp_r >= EMAX_X);
  assign range_ufl = exp_r[XW-1] || (exp_r == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
      sign_r    <= 1'b0;
      spec_zero <= 1'b0;
      spec_inf  <= 1'b0;
      exp_a     <= '0;
      exp_b     <= '0;
      man_a     <= '0;
      man_b     <= '0;
      prod      <= '0;
      exp_r     <= '0;
      man_r     <= '0;
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sign_r    <= a[W-1] ^ b[W-1];
            spec_zero <= a_exp_zero || b_exp_zero;
            spec_inf  <= a_exp_ones || b_exp_ones;
            exp_a     <= a[W-2:MAN_W];
            exp_b     <= b[W-2:MAN_W];
            man_a     <= a[MAN_W-1:0];
            man_b     <= b[MAN_W-1:0];
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
            state     <= S_MUL;
          end
        end
        S_MUL: begin
          prod  <= mul_a * mul_b;
          exp_r <= exp_sum;
          state <= S_NORM;
        end
        S_NORM: begin
          man_r    <= norm_man;
          guard_r  <= norm_guard;
          sticky_r <= norm_sticky;
          exp_r    <= norm_exp;
          state    <= S_ROUND;
        end
        S_ROUND: begin
          man_r <= rnd_man;
          exp_r <= rnd_exp;
          state <= S_DONE;
        end
        S_DONE: begin
          // Zero operands win over infinite ones; specials bypass the range check entirely.
          if (spec_zero) begin
            result <= {sign_r, {(W - 1){1'b0}}};
            zero   <= 1'b1;
          end else if (spec_inf || range_ovf) begin
            result   <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow <= 1'b1;
          end else if (range_ufl) begin
            result    <= {sign_r, {(W - 1){1'b0}}};
            underflow <= 1'b1;
            zero      <= 1'b1;
          end else begin
            result <= {sign_r, exp_r[EXP_W-1:0], man_r};
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Parametrised sequential floating-point multiplier; next generation of the fixed single-precision, counter-sequenced multiplier.
- Owns its sequencing FSM and uses a start/done handshake, so it needs no external step counter.
- Adds a generic exponent/mantissa width, single-step normalisation, selectable round-to-nearest-even, and zero, overflow and underflow flags.
- Sits in the calculator datapath beside the add/sub units and is driven by the operation controller.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width (hidden bit excluded).
- ROUND, 1, 1 = round-to-nearest-even, 0 = truncate.
- BIAS (localparam), 2^(EXP_W-1)-1, exponent bias.
- W (localparam), 1+EXP_W+MAN_W, word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation request; sampled only in IDLE.
- a  in  W  operand A {sign, exp, man}.
- b  in  W  operand B.
- busy  out  1  high while in MUL, NORM or ROUND.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  W  product.
- overflow  out  1  result saturated to infinity.
- underflow  out  1  result flushed to zero from a nonzero exact product.
- zero  out  1  result magnitude is zero.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- While rst_n=0: FSM to IDLE; busy, done, result, overflow, underflow, zero and all internal registers to 0, regardless of clk. Reset asserted mid-operation aborts that operation and produces no done.
- FSM transitions: IDLE -(start)-> MUL -> NORM -> ROUND -> DONE -> IDLE.
- Start accepted at edge t0 (operands captured at t0): done=1 during the cycle after edge t0+4. One operation per 5 cycles minimum.
- start outside IDLE is ignored; operands are not re-sampled.
- result and flags hold their values from DONE until the next accepted start. On acceptance, all flags clear.
- MUL:
  - sign = a[W-1]^b[W-1].
  - P = {1,ma}*{1,mb}, 2*MAN_W+2 bits.
  - E = ea+eb-BIAS, signed, EXP_W+2 bits.
- NORM:
  - If P[MSB]=1: mantissa = P[2MAN_W:MAN_W+1], guard = P[MAN_W], sticky = OR(P[MAN_W-1:0]), E=E+1.
  - Else: mantissa = P[2MAN_W-1:MAN_W], guard = P[MAN_W-1], sticky = OR(P[MAN_W-2:0]).
  - Exactly one shift maximum; no iterative loop.
- ROUND:
  - ROUND=1: increment the mantissa if guard & (sticky | mantissa LSB).
  - Mantissa carry-out: mantissa = 0, E=E+1.
  - ROUND=0: no increment.
- Range check after rounding:
  - E >= 2^EXP_W-1: result = {sign, all-ones, 0}, overflow=1.
  - E <= 0: result = {sign, 0}, underflow=1, zero=1.
  - Otherwise: result = {sign, E[EXP_W-1:0], mantissa}.
- Special operands, decided at capture with this priority:
  - Exp field 0 on either operand (zero or denormal, flush-to-zero): result = {sign, 0}, zero=1, overflow=0, underflow=0.
  - Else, exp field all-ones on either operand: result = {sign, all-ones, 0}, overflow=1. No NaN generation.
  - The FSM still traverses every state, so latency is constant.
- The sign of a zero or infinity result is always sign (the XOR of the operand signs).

Test Plan:
- Default params: a=0x40000000 (2.0), b=0x40400000 (3.0), start pulse -> done after 5 cycles, result=0x40C00000, all flags 0, busy high for exactly 3 cycles.
- a=0x3FC00000, b=0x3FC00000 (1.5*1.5), normalise-shift path -> result=0x40100000.
- a=0x3F800001, b=0x3FC00000 (rounding) -> ROUND=1: result=0x3FC00002; ROUND=0 build: result=0x3FC00001.
- Range limits:
  - a=b=0x7F000000 -> result=0x7F800000, overflow=1.
  - a=b=0x00800000 -> result=0x00000000, underflow=1, zero=1.
  - a=0x00000000, b=0xC0000000 -> result=0x80000000, zero=1, underflow=0.
- Protocol:
  - Second start with different operands one cycle after acceptance -> ignored; first result is unchanged.
  - rst_n low for 1 cycle during NORM -> all outputs 0 immediately, no done pulse.
  - Next start after reset -> completes normally.
- EXP_W=5, MAN_W=10 build (half precision): a=0x4000, b=0x4200 (2.0*3.0) -> result=0x4600.
